fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Multi-cycle fetch stage that sits directly upstream of the instruction memory. It owns the PC and drives the memory's select and read address. It captures the registered instruction word into an instruction register (IR) and hands it to the downstream decode/control FSM over a valid/ready handshake. It also handles PC redirects (branch/jump) and flags misaligned or out-of-range fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
IMEM_WORDS, 32, instruction memory depth in 32-bit words; legal fetch range is 0 .. IMEM_WORDS*4-4.

Ports:
clk  input  1  system clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  fetch permitted; when 0 the unit parks in IDLE after the current handshake.
imem_sel  output  1  instruction memory select; 0 = read this cycle, 1 = idle.
imem_addr  output  32  byte read address to instruction memory (always equals pc).
imem_instruction  input  32  registered memory output, valid the cycle after imem_sel=0.
ir_valid  output  1  IR holds an instruction for downstream.
ir_ready  input  1  downstream accepts the IR this cycle.
ir  output  32  instruction register.
ir_pc  output  32  PC of the instruction held in ir.
redirect_valid  input  1  load redirect_pc as the next fetch PC.
redirect_pc  input  32  redirect target (byte address).
fetch_fault  output  1  sticky fault indicator.
fault_cause  output  2  2'b01 = misaligned PC, 2'b10 = PC out of range, 2'b00 = none.
fetch_count  output  32  number of completed ir handshakes since reset; wraps at 2^32.

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0.
  - fetch_fault=0, fault_cause=0, fetch_count=0.
  - imem_sel=1, imem_addr=RESET_PC.
  - Reset mid-fetch discards everything in flight.
- Decode rules: imem_sel is decoded from state; it is 0 only in FETCH with a legal pc. imem_addr=pc at all times.
- States:
  - IDLE: if enable=1, go to FETCH next cycle.
  - FETCH: pc is checked combinationally.
    - pc[1:0]!=0: imem_sel stays 1, go to FAULT, cause 01.
    - pc>=IMEM_WORDS*4: imem_sel stays 1, go to FAULT, cause 10. Misaligned takes priority.
    - Otherwise: imem_sel=0, go to CAPTURE.
  - CAPTURE: imem_sel=1; ir<=imem_instruction, ir_pc<=pc, ir_valid<=1; go to VALID.
  - VALID: ir_valid=1; ir and ir_pc are held stable until handshake.
    - On ir_valid&ir_ready: fetch_count+=1, pc<=pc+4 (32-bit wrap), ir_valid<=0.
    - Then go to FETCH if enable=1, else IDLE.
  - FAULT: fetch_fault=1, imem_sel=1, ir_valid=0. Stays here until redirect.
- Latency: first ir_valid appears 3 cycles after reset release with enable=1 (IDLE, FETCH, CAPTURE). Back-to-back throughput is one instruction per 3 cycles when ir_ready=1 (FETCH, CAPTURE, VALID).
- Redirect (any state, highest priority):
  - pc<=redirect_pc and ir_valid<=0; an IR pending in VALID is dropped (no count increment even if ir_ready=1 the same cycle).
  - fetch_fault and fault_cause are cleared.
  - Next state is FETCH if enable=1, else IDLE.
  - A redirect in FETCH abandons that read; the memory word latched on that edge is ignored.
  - The alignment and range check of the new pc happens in FETCH as normal.
- enable=0 never aborts an in-progress FETCH/CAPTURE/VALID sequence; it only gates the next fetch.
- ir_ready while ir_valid=0 has no effect.

Test Plan:
- Reset release, enable=1, memory words 0x00500093, 0x00108113: first ir=0x00500093, ir_pc=0 valid at cycle 3; with ir_ready=1, second ir=0x00108113, ir_pc=4 three cycles later; fetch_count=2.
- Hold ir_ready=0 for 5 cycles in VALID: ir, ir_pc and ir_valid stable and imem_sel=1 throughout; pc increments only after ir_ready=1.
- Redirect to 0x10 while in VALID with ir_ready=1 in the same cycle: IR dropped, fetch_count unchanged, next imem_addr=0x10 with imem_sel=0, next ir_pc=0x10.
- redirect_pc=0x0000_0006: FAULT, fetch_fault=1, fault_cause=01, imem_sel never 0; then redirect to 0x8 clears the fault and fetch resumes at 0x8.
- Sequential fetch up to pc=0x7C, then handshake: pc=0x80 gives FAULT with cause 10 and no memory read issued.
- Assert rst_n=0 during CAPTURE: outputs return to reset values immediately (asynchronously); fetch restarts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Multi-cycle instruction fetch stage that owns the PC, reads
//               instruction memory and hands the instruction register to
//               decode over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        imem_sel,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instruction,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fetch_count
);

  // One extra bit keeps the limit exact even for a full 4 GiB memory
  localparam logic [32:0] c_pc_limit = 33'(IMEM_WORDS) * 33'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_VALID   = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_ir_pc;
  logic        r_ir_valid;
  logic        r_fetch_fault;
  logic [1:0]  r_fault_cause;
  logic [31:0] r_fetch_count;

  logic w_misaligned;
  logic w_out_of_range;
  logic w_handshake;

  assign w_misaligned   = (r_pc[1:0] != 2'b00);
  assign w_out_of_range = ({1'b0, r_pc} >= c_pc_limit);
  assign w_handshake    = r_ir_valid && ir_ready;

  assign imem_sel    = !((r_state == S_FETCH) && !w_misaligned && !w_out_of_range);
  assign imem_addr   = r_pc;
  assign ir_valid    = r_ir_valid;
  assign ir          = r_ir;
  assign ir_pc       = r_ir_pc;
  assign fetch_fault = r_fetch_fault;
  assign fault_cause = r_fault_cause;
  assign fetch_count = r_fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_ir          <= 32'h0;
      r_ir_pc       <= 32'h0;
      r_ir_valid    <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fault_cause <= 2'b00;
      r_fetch_count <= 32'h0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a same-cycle handshake
      r_pc          <= redirect_pc;
      r_ir_valid    <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fault_cause <= 2'b00;
      r_state       <= enable ? S_FETCH : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_misaligned) begin
            r_fetch_fault <= 1'b1;
            r_fault_cause <= 2'b01;
            r_state       <= S_FAULT;
          end else if (w_out_of_range) begin
            r_fetch_fault <= 1'b1;
            r_fault_cause <= 2'b10;
            r_state       <= S_FAULT;
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_ir       <= imem_instruction;
          r_ir_pc    <= r_pc;
          r_ir_valid <= 1'b1;
          r_state    <= S_VALID;
        end
        S_VALID: begin
          if (w_handshake) begin
            r_fetch_count <= r_fetch_count + 32'd1;
            r_pc          <= r_pc + 32'd4;
            r_ir_valid    <= 1'b0;
            r_state       <= enable ? S_FETCH : S_IDLE;
          end
        end
        S_FAULT: begin
          r_ir_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit; expected instruction streams
//               and faults are queued at redirect time and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int WORDS = 32;
  localparam int LIMIT = WORDS * 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        imem_sel;
  logic [31:0] imem_addr;
  logic [31:0] imem_instruction = 32'h0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .imem_sel(imem_sel), .imem_addr(imem_addr), .imem_instruction(imem_instruction),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_fault(fetch_fault), .fault_cause(fault_cause), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [WORDS];

  // Registered instruction memory: word appears the cycle after the select
  always @(posedge clk) begin
    if (!imem_sel) imem_instruction <= mem[imem_addr[6:2]];
  end

  typedef struct {
    bit          is_fault;
    logic [31:0] data;
    logic [31:0] pc;
    logic [1:0]  cause;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          rand_mode = 0;
  logic [31:0] pushed_count = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      ir_ready = ($urandom_range(0, 2) != 0);
      enable   = ($urandom_range(0, 3) != 0);
    end
  endtask

  // Sequential fetch from t runs to the end of memory and then faults
  task automatic push_target(input logic [31:0] t);
    exp_t        e;
    logic [32:0] p;
    if (t[1:0] != 2'b00) begin
      e = '{is_fault: 1'b1, data: 32'h0, pc: 32'h0, cause: 2'b01};
      sb.push_back(e);
    end else begin
      p = {1'b0, t};
      while (p < 33'(LIMIT)) begin
        e = '{is_fault: 1'b0, data: mem[p[6:2]], pc: p[31:0], cause: 2'b00};
        sb.push_back(e);
        pushed_count = pushed_count + 32'd1;
        p = p + 33'd4;
      end
      e = '{is_fault: 1'b1, data: 32'h0, pc: 32'h0, cause: 2'b10};
      sb.push_back(e);
    end
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk({name, " drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " ir_valid"}, 32'(ir_valid), 32'd0);
    chk({tag, " imem_sel"}, 32'(imem_sel), 32'd1);
    chk({tag, " imem_addr"}, imem_addr, 32'h0);
    chk({tag, " ir"}, ir, 32'h0);
    chk({tag, " ir_pc"}, ir_pc, 32'h0);
    chk({tag, " fetch_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, " fault_cause"}, 32'(fault_cause), 32'd0);
    chk({tag, " fetch_count"}, fetch_count, 32'h0);
  endtask

  // Monitor: pops one expectation per handshake or per fault onset
  initial begin
    logic prev_fault;
    exp_t e;
    prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_fault = 1'b0;
      end else begin
        if (!imem_sel)
          chk("read address legal", 32'((imem_addr[1:0] == 2'b00) && (imem_addr < LIMIT)), 32'd1);
        if (ir_valid && ir_ready && !redirect_valid) begin
          if (sb.size() == 0 || sb[0].is_fault) begin
            chk("unexpected handshake ir_pc", ir_pc, 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("handshake ir", ir, e.data);
            chk("handshake ir_pc", ir_pc, e.pc);
          end
        end
        if (fetch_fault && !prev_fault) begin
          if (sb.size() == 0 || !sb[0].is_fault) begin
            chk("unexpected fault cause", 32'(fault_cause), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            chk("fault cause", 32'(fault_cause), 32'(e.cause));
          end
        end
        prev_fault = fetch_fault;
      end
    end
  end

  initial begin
    int          n;
    logic [31:0] t;
    int          r;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h0010_8113;

    // Reset values
    enable = 1'b1;
    repeat (3) tick();
    check_reset("reset");

    // First fetch latency and stall in VALID
    sb.push_back('{is_fault: 1'b0, data: mem[0], pc: 32'h0, cause: 2'b00});
    sb.push_back('{is_fault: 1'b0, data: mem[1], pc: 32'h4, cause: 2'b00});
    pushed_count = 32'd2;
    rst_n = 1'b1;
    n = 0;
    while (!ir_valid && n < 20) begin
      tick();
      n++;
    end
    chk("first valid latency", 32'(n), 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("stall ir", ir, 32'h0050_0093);
      chk("stall ir_valid/imem_sel", {30'h0, ir_valid, imem_sel}, 32'h3);
      chk("stall pc", imem_addr, 32'h0);
      tick();
    end
    ir_ready = 1'b1;
    tick();
    enable = 1'b0;
    chk("pc after handshake", imem_addr, 32'h4);
    n = 0;
    while (!ir_valid && n < 20) begin
      tick();
      n++;
    end
    chk("handshake spacing", 32'(n + 1), 32'd3);
    tick();
    chk("fetch_count after two", fetch_count, 32'd2);
    repeat (3) tick();
    chk("parked idle", {30'h0, ir_valid, imem_sel}, 32'h1);

    // Redirect in VALID with ir_ready the same cycle drops the IR
    ir_ready = 1'b0;
    enable   = 1'b1;
    n = 0;
    while (!ir_valid && n < 20) begin
      tick();
      n++;
    end
    chk("pending ir_pc", ir_pc, 32'h8);
    sb.push_back('{is_fault: 1'b0, data: mem[4], pc: 32'h10, cause: 2'b00});
    pushed_count = pushed_count + 32'd1;
    ir_ready = 1'b1;
    do_redirect(32'h10);
    ir_ready = 1'b0;
    chk("redirect imem_addr", imem_addr, 32'h10);
    chk("redirect imem_sel", 32'(imem_sel), 32'd0);
    chk("redirect count unchanged", fetch_count, 32'd2);
    enable   = 1'b0;
    ir_ready = 1'b1;
    wait_drain("redirect 0x10");
    chk("count after redirect", fetch_count, pushed_count);

    // Misaligned redirect, then recovery runs to the end of memory
    enable = 1'b1;
    push_target(32'h6);
    do_redirect(32'h6);
    wait_drain("misaligned");
    chk("misaligned fault", {29'h0, fetch_fault, fault_cause}, 32'h5);
    chk("fault ir_valid", 32'(ir_valid), 32'd0);
    push_target(32'h8);
    do_redirect(32'h8);
    chk("fault cleared", {29'h0, fetch_fault, fault_cause}, 32'h0);
    wait_drain("stream from 0x8");
    chk("range fault", {29'h0, fetch_fault, fault_cause}, 32'h6);
    chk("range fault addr", imem_addr, 32'h80);
    chk("count after stream", fetch_count, pushed_count);

    // Asynchronous reset during CAPTURE
    do_redirect(32'h20);
    tick();
    rst_n = 1'b0;
    #1;
    sb.delete();
    pushed_count = 32'h0;
    check_reset("async reset");
    tick();
    push_target(32'h0);
    rst_n = 1'b1;
    rand_mode = 1;
    wait_drain("restart");
    chk("count after restart", fetch_count, pushed_count);

    // Randomized redirect targets with random enable/ready
    for (int k = 0; k < 15; k++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      t = 32'($urandom_range(0, WORDS - 1)) << 2;
      else if (r < 85) t = (32'($urandom_range(0, WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r < 95) t = 32'($urandom_range(WORDS, 4000)) << 2;
      else             t = 32'hFFFF_FFFC;
      push_target(t);
      do_redirect(t);
      wait_drain("random");
      chk("random count", fetch_count, pushed_count);
      chk("random ends in fault", 32'(fetch_fault), 32'd1);
    end

    rand_mode = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
